// File: rtl/mp3_pkg.sv
// Shared types and default timing for the MP3 trigger sequencer.
// Defaults assume a 100 MHz clock: 50 ms trigger pulse, 1 s forced gap.
package mp3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_PULSE_CYCLES = 5_000_000;
  localparam int DEF_GAP_CYCLES   = 100_000_000;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mp3_cycle_timer.sv
// Loadable down-counter that stops at zero; o_done is high while the count is zero.
module mp3_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/mp3_trigger_sequencer.sv
// Sequences one-hot trigger pulses to MP3 output stages: PULSE, then a forced GAP,
// with a single pending request slot. Each pasar bit feeds one external output stage.
module mp3_trigger_sequencer
  import mp3_pkg::*;
#(
  parameter int N_TRACKS     = 4,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [1:0]          req_track,
  output logic                req_ready,
  input  logic                abort,
  output logic [N_TRACKS-1:0] pasar,
  output logic                busy
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t              r_state;
  logic                r_pend_valid;
  logic [1:0]          r_pend_track;
  logic [N_TRACKS-1:0] r_pasar;

  state_t              w_state_nxt;
  logic                w_pend_valid_nxt;
  logic [1:0]          w_pend_track_nxt;
  logic [N_TRACKS-1:0] w_pasar_nxt;
  logic                w_load;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_timer_done;
  logic                w_handshake;

  mp3_cycle_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  assign w_handshake = req_valid && !r_pend_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_track <= '0;
      r_pasar      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_track <= w_pend_track_nxt;
      r_pasar      <= w_pasar_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_track_nxt = r_pend_track;
    w_pasar_nxt      = '0;
    w_load           = 1'b0;
    w_load_val       = PULSE_LOAD;
    unique case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_state_nxt = ST_PULSE;
          w_pasar_nxt = N_TRACKS'(onehot4(req_track));
          w_load      = 1'b1;
        end
      end
      ST_PULSE: begin
        if (abort) begin
          w_state_nxt      = ST_GAP;
          w_pend_valid_nxt = 1'b0;
          w_load           = 1'b1;
          w_load_val       = GAP_LOAD;
        end else begin
          if (w_handshake) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_track_nxt = req_track;
          end
          if (w_timer_done) begin
            w_state_nxt = ST_GAP;
            w_load      = 1'b1;
            w_load_val  = GAP_LOAD;
          end else begin
            w_pasar_nxt = r_pasar;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_pend_valid_nxt = 1'b0;
        end else if (w_handshake && !w_timer_done) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_track_nxt = req_track;
        end
        // A request landing on the last GAP cycle starts directly, never parking in IDLE.
        if (w_timer_done) begin
          if (r_pend_valid && !abort) begin
            w_state_nxt      = ST_PULSE;
            w_pasar_nxt      = N_TRACKS'(onehot4(r_pend_track));
            w_pend_valid_nxt = 1'b0;
            w_load           = 1'b1;
          end else if (w_handshake && !abort) begin
            w_state_nxt = ST_PULSE;
            w_pasar_nxt = N_TRACKS'(onehot4(req_track));
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = !r_pend_valid;
    busy      = (r_state != ST_IDLE);
  end

  assign pasar = r_pasar;

endmodule

// File: tb/tb_mp3_trigger_sequencer.sv
// Self-checking bench: directed timelines with PULSE_CYCLES=4, GAP_CYCLES=6,
// plus a randomized run compared against a queue-based behavioural model.
module tb_mp3_trigger_sequencer;

  localparam int PULSE = 4;
  localparam int GAP   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_track = 2'd0;
  logic       abort = 1'b0;
  logic       req_ready;
  logic [3:0] pasar;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: cycles left in the pulse/gap, and a waiting list of tracks.
  int         m_pulse_left;
  int         m_gap_left;
  logic [1:0] m_track;
  logic [1:0] m_wait[$];

  mp3_trigger_sequencer #(
    .N_TRACKS     (4),
    .PULSE_CYCLES (PULSE),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_track (req_track),
    .req_ready (req_ready),
    .abort     (abort),
    .pasar     (pasar),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pulse_left = 0;
    m_gap_left   = 0;
    m_track      = 2'd0;
    m_wait.delete();
  endtask

  task automatic model_step(input logic v, input logic [1:0] t, input logic ab);
    bit ready;
    bit hs;
    ready = (m_wait.size() == 0);
    hs    = v && ready;
    if (m_pulse_left == 0 && m_gap_left == 0) begin
      if (hs) begin
        m_pulse_left = PULSE;
        m_track      = t;
      end
    end else if (ab) begin
      m_wait.delete();
      if (m_pulse_left > 0) begin
        m_pulse_left = 0;
        m_gap_left   = GAP;
      end else begin
        m_gap_left--;
      end
    end else if (m_pulse_left > 0) begin
      if (hs) m_wait.push_back(t);
      m_pulse_left--;
      if (m_pulse_left == 0) m_gap_left = GAP;
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        if (m_wait.size() > 0) begin
          m_track      = m_wait.pop_front();
          m_pulse_left = PULSE;
        end else if (hs) begin
          m_track      = t;
          m_pulse_left = PULSE;
        end
      end else if (hs) begin
        m_wait.push_back(t);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_track = 2'd1;
    abort     = 1'b0;
    repeat (3) next_cycle();
    n_checks++;
    if (pasar !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pasar: got %b expected 0000", pasar);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    next_cycle();
  endtask

  // Request track 2 at local cycle 0; expects to start from IDLE.
  task automatic test_single_request();
    logic [3:0] exp_pasar;
    logic       exp_busy;
    for (int c = 0; c <= 12; c++) begin
      exp_pasar = (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000;
      exp_busy  = (c >= 1 && c <= 10);
      n_checks++;
      if (pasar !== exp_pasar) begin
        n_fail++;
        $display("FAIL single_pasar cycle %0d: got %b expected %b", c, pasar, exp_pasar);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL single_busy cycle %0d: got %b expected %b", c, busy, exp_busy);
      end
      req_valid = (c == 0);
      req_track = 2'd2;
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  // Track 1 at cycle 0, track 3 at cycle 2; optionally a third request while the slot is full.
  task automatic test_queued_request(input bit with_third);
    logic [3:0] exp_pasar;
    logic       exp_ready;
    logic       exp_busy;
    logic [3:0] prev_pasar;
    int         n_pulses;
    logic [3:0] first_pulse;
    logic [3:0] second_pulse;
    prev_pasar   = 4'b0000;
    n_pulses     = 0;
    first_pulse  = 4'b0000;
    second_pulse = 4'b0000;
    for (int c = 0; c <= 24; c++) begin
      if (c >= 1 && c <= 4)        exp_pasar = 4'b0010;
      else if (c >= 11 && c <= 14) exp_pasar = 4'b1000;
      else                         exp_pasar = 4'b0000;
      exp_ready = !(c >= 3 && c <= 10);
      exp_busy  = (c >= 1 && c <= 20);
      n_checks++;
      if (pasar !== exp_pasar) begin
        n_fail++;
        $display("FAIL queued_pasar cycle %0d: got %b expected %b", c, pasar, exp_pasar);
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL queued_ready cycle %0d: got %b expected %b", c, req_ready, exp_ready);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL queued_busy cycle %0d: got %b expected %b", c, busy, exp_busy);
      end
      if (pasar != 4'b0000 && prev_pasar == 4'b0000) begin
        n_pulses++;
        if (n_pulses == 1) first_pulse = pasar;
        if (n_pulses == 2) second_pulse = pasar;
      end
      prev_pasar = pasar;
      if (c == 0) begin
        req_valid = 1'b1;
        req_track = 2'd1;
      end else if (c == 2) begin
        req_valid = 1'b1;
        req_track = 2'd3;
      end else if (with_third && c >= 4 && c <= 9) begin
        req_valid = 1'b1;
        req_track = 2'd2;
      end else begin
        req_valid = 1'b0;
      end
      next_cycle();
    end
    req_valid = 1'b0;
    n_checks++;
    if (n_pulses !== 2 || first_pulse !== 4'b0010 || second_pulse !== 4'b1000) begin
      n_fail++;
      $display("FAIL queued_pulse_count: got %0d pulses (%b, %b) expected 2 pulses (0010, 1000)",
               n_pulses, first_pulse, second_pulse);
    end
  endtask

  // Track 0 at cycle 0, track 2 queued at cycle 1, abort at cycle 2.
  task automatic test_abort();
    logic [3:0] exp_pasar;
    logic       exp_busy;
    logic       exp_ready;
    for (int c = 0; c <= 14; c++) begin
      exp_pasar = (c == 1 || c == 2) ? 4'b0001 : 4'b0000;
      exp_busy  = (c >= 1 && c <= 8);
      exp_ready = (c != 2);
      n_checks++;
      if (pasar !== exp_pasar) begin
        n_fail++;
        $display("FAIL abort_pasar cycle %0d: got %b expected %b", c, pasar, exp_pasar);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL abort_busy cycle %0d: got %b expected %b", c, busy, exp_busy);
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL abort_ready cycle %0d: got %b expected %b", c, req_ready, exp_ready);
      end
      req_valid = (c == 0 || c == 1);
      req_track = (c == 0) ? 2'd0 : 2'd2;
      abort     = (c == 2);
      next_cycle();
    end
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    req_valid = 1'b1;
    req_track = 2'd2;
    next_cycle();
    req_valid = 1'b0;
    n_checks++;
    if (pasar !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_pre_pasar: got %b expected 0100", pasar);
    end
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    n_checks++;
    if (pasar !== 4'b0000 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: got pasar=%b busy=%b ready=%b expected 0000 0 1",
               pasar, busy, req_ready);
    end
    rst_n = 1'b1;
    test_single_request();
  endtask

  task automatic test_random();
    logic [3:0] exp_pasar;
    logic [3:0] one;
    logic       exp_busy;
    logic       exp_ready;
    logic       v;
    logic       ab;
    logic       r;
    logic [1:0] t;
    one   = 4'b0001;
    rst_n = 1'b0;
    req_valid = 1'b0;
    abort = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10000; i++) begin
      exp_pasar = (m_pulse_left > 0) ? (one << m_track) : 4'b0000;
      exp_busy  = (m_pulse_left > 0) || (m_gap_left > 0);
      exp_ready = (m_wait.size() == 0);
      n_checks++;
      if (pasar !== exp_pasar) begin
        n_fail++;
        $display("FAIL rand_pasar step %0d: got %b expected %b", i, pasar, exp_pasar);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_busy step %0d: got %b expected %b", i, busy, exp_busy);
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready step %0d: got %b expected %b", i, req_ready, exp_ready);
      end
      n_checks++;
      assert ($countones(pasar) <= 1 && (pasar == 4'b0000 || busy)) else begin
        n_fail++;
        $display("FAIL rand_onehot step %0d: got pasar=%b busy=%b", i, pasar, busy);
      end
      v  = ($urandom_range(0, 2) == 0);
      t  = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 999) == 0);
      req_valid = v;
      req_track = t;
      abort     = ab;
      rst_n     = !r;
      if (r) model_reset();
      else   model_step(v, t, ab);
      next_cycle();
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_queued_request(1'b0);
    test_queued_request(1'b1);
    test_abort();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
